// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory access unit (master) and the data memory (slave).
// Handshake: the master raises available with every request field held stable; the slave answers with
// busy (access running) or a fault flag, and re-accepts only after available has been sampled low once.
interface mem_responder_if;
    logic        available;
    logic        is_write;
    logic        is_unsigned;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] in;
    logic [31:0] out;
    logic        busy;
    logic        op_fault;
    logic        addr_fault;
    logic        access_fault;

    modport master (
        output available, is_write, is_unsigned, op, addr, in,
        input  out, busy, op_fault, addr_fault, access_fault
    );

    modport slave (
        input  available, is_write, is_unsigned, op, addr, in,
        output out, busy, op_fault, addr_fault, access_fault
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data memory answering byte/half/word requests with programmable wait states
// and op/alignment/range fault reporting; faulted requests never touch the RAM.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic [1:0]      dbg_state
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               op_fault_q, op_fault_d;
    logic               addr_fault_q, addr_fault_d;
    logic               access_fault_q, access_fault_d;
    logic [31:0]        out_q, out_d;
    logic               wr_q, wr_d;
    logic               uns_q, uns_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         lane_q, lane_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        off;
    logic               req_op_f, req_mis, req_oor, req_any_f;
    logic [31:0]        rd_word, rd_ext, wr_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               mem_we;

    // Addresses below BASE_ADDR wrap to huge offsets and therefore fail the range test.
    assign off       = bus.addr - BASE_ADDR;
    assign req_op_f  = (bus.op == 2'b11);
    assign req_mis   = (bus.op[1] & |bus.addr[1:0]) | (bus.op[0] & bus.addr[0]);
    assign req_oor   = ({1'b0, off} >= SPAN);
    assign req_any_f = req_op_f | req_mis | req_oor;

    assign rd_word = mem[idx_q];
    assign mem_we  = (state_q == ACCESS) && (cnt_q == 4'd0) && wr_q;

    always_comb begin
        rd_byte = rd_word[8*lane_q +: 8];
        rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_q)
            2'b00:   rd_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: rd_ext = rd_word;
        endcase
    end

    // Read-modify-write merge: only the addressed lanes take new data.
    always_comb begin
        wr_word = rd_word;
        case (op_q)
            2'b00:   wr_word[8*lane_q +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1]) wr_word[31:16] = wdata_q[15:0];
                else           wr_word[15:0]  = wdata_q[15:0];
            end
            default: wr_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        op_fault_d     = op_fault_q;
        addr_fault_d   = addr_fault_q;
        access_fault_d = access_fault_q;
        out_d          = out_q;
        wr_d           = wr_q;
        uns_d          = uns_q;
        op_d           = op_q;
        lane_d         = lane_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.available) begin
                    if (req_any_f) begin
                        op_fault_d     = req_op_f;
                        addr_fault_d   = ~req_op_f & req_mis;
                        access_fault_d = ~req_op_f & (req_mis | req_oor);
                        state_d        = FAULT;
                    end else begin
                        wr_d    = bus.is_write;
                        uns_d   = bus.is_unsigned;
                        op_d    = bus.op;
                        lane_d  = bus.addr[1:0];
                        idx_d   = off[IDX_W+1:2];
                        wdata_d = bus.in;
                        busy_d  = 1'b1;
                        cnt_d   = WS;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                    if (!wr_q) out_d = rd_ext;
                end
            end
            DONE: begin
                if (!bus.available) state_d = IDLE;
            end
            FAULT: begin
                if (!bus.available) begin
                    op_fault_d     = 1'b0;
                    addr_fault_d   = 1'b0;
                    access_fault_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            busy_q         <= 1'b0;
            op_fault_q     <= 1'b0;
            addr_fault_q   <= 1'b0;
            access_fault_q <= 1'b0;
            out_q          <= 32'h0;
            wr_q           <= 1'b0;
            uns_q          <= 1'b0;
            op_q           <= 2'b00;
            lane_q         <= 2'b00;
            idx_q          <= '0;
            wdata_q        <= 32'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            op_fault_q     <= op_fault_d;
            addr_fault_q   <= addr_fault_d;
            access_fault_q <= access_fault_d;
            out_q          <= out_d;
            wr_q           <= wr_d;
            uns_q          <= uns_d;
            op_q           <= op_d;
            lane_q         <= lane_d;
            idx_q          <= idx_d;
            wdata_q        <= wdata_d;
        end
    end

    // RAM contents survive reset; a reset during ACCESS forces IDLE, so the pending write never fires.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wr_word;
    end

    assign bus.out          = out_q;
    assign bus.busy         = busy_q;
    assign bus.op_fault     = op_fault_q;
    assign bus.addr_fault   = addr_fault_q;
    assign bus.access_fault = access_fault_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: two instances (base 0 / 1 wait state and
// base 0x1000 / 0 wait states) share one driver; a byte-level reference memory predicts every answer.
module tb_mem_responder;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        avail, is_wr, is_uns;
  logic [1:0]  op;
  logic [31:0] addr, wdata;
  int          sel;

  mem_responder_if ifa();
  mem_responder_if ifb();
  logic [1:0] dbg_a, dbg_b;

  assign ifa.available   = avail && (sel == 0);
  assign ifa.is_write    = is_wr;
  assign ifa.is_unsigned = is_uns;
  assign ifa.op          = op;
  assign ifa.addr        = addr;
  assign ifa.in          = wdata;
  assign ifb.available   = avail && (sel == 1);
  assign ifb.is_write    = is_wr;
  assign ifb.is_unsigned = is_uns;
  assign ifb.op          = op;
  assign ifb.addr        = addr;
  assign ifb.in          = wdata;

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .reset(rst_n), .bus(ifa), .dbg_state(dbg_a)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .bus(ifb), .dbg_state(dbg_b)
  );

  logic        busy_s, opf_s, adf_s, acf_s;
  logic [31:0] out_s;
  always_comb begin
    busy_s = ifa.busy; opf_s = ifa.op_fault; adf_s = ifa.addr_fault; acf_s = ifa.access_fault; out_s = ifa.out;
    if (sel == 1) begin
      busy_s = ifb.busy; opf_s = ifb.op_fault; adf_s = ifb.addr_fault; acf_s = ifb.access_fault; out_s = ifb.out;
    end
  end

  // Entry: [40] check out, [39:37] op/addr/access fault, [36:5] out, [4:0] busy cycles.
  logic [40:0] exp_q[$];
  int errors = 0, checks = 0, resp_cnt = 0;
  logic [31:0] ref_mem [2][DEPTH];

  function automatic logic [31:0] base_of(input int s);
    return (s == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int ws_of(input int s);
    return (s == 1) ? 0 : 1;
  endfunction

  function automatic logic [40:0] model(input int s, input bit w, input bit u, input logic [1:0] o,
                                        input logic [31:0] a, input logic [31:0] d);
    int size, idx, b;
    bit opf, mis, oor;
    logic [31:0] off, val;
    opf  = (o == 2'b11);
    size = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : 4;
    mis  = !opf && ((a % size) != 0);
    off  = a - base_of(s);
    oor  = (off >= 32'(4 * DEPTH));
    if (opf || mis || oor) return {1'b0, opf, mis, !opf && (mis || oor), 32'h0, 5'd0};
    idx = int'(off / 4);
    b   = int'(a % 4);
    val = 32'h0;
    for (int k = 0; k < size; k++) begin
      if (w) ref_mem[s][idx][8*(b+k) +: 8] = d[8*k +: 8];
      else   val[8*k +: 8] = ref_mem[s][idx][8*(b+k) +: 8];
    end
    if (!w && !u && size < 4 && val[8*size-1])
      for (int k = size; k < 4; k++) val[8*k +: 8] = 8'hFF;
    return {!w, 3'b000, val, 5'(ws_of(s) + 1)};
  endfunction

  // Monitor: a response is busy falling or a fault flag appearing.
  int blen = 0;
  bit p_busy = 0, p_flt = 0;
  always @(posedge clk) begin
    logic [40:0] e;
    bit resp;
    #1;
    if (!rst_n) begin
      p_busy = 0; p_flt = 0; blen = 0;
    end else begin
      if (busy_s) blen++;
      resp = (p_busy && !busy_s) || (!p_flt && (opf_s || adf_s || acf_s));
      if (resp) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: busy=%0b faults=%b with nothing expected", busy_s, {opf_s, adf_s, acf_s});
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({opf_s, adf_s, acf_s} !== e[39:37]) begin
            errors++;
            $display("FAIL faults: got %b want %b", {opf_s, adf_s, acf_s}, e[39:37]);
          end
          checks++;
          if (blen !== int'(e[4:0])) begin
            errors++;
            $display("FAIL busy_len: got %0d want %0d", blen, e[4:0]);
          end
          if (e[40]) begin
            checks++;
            if (out_s !== e[36:5]) begin
              errors++;
              $display("FAIL read_data: got %h want %h", out_s, e[36:5]);
            end
          end
        end
        blen = 0;
        resp_cnt++;
      end
      p_busy = busy_s;
      p_flt  = opf_s || adf_s || acf_s;
    end
  end

  task automatic do_req(input int s, input bit w, input bit u, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] d, input int hold);
    logic [40:0] e;
    int start;
    bit got;
    e = model(s, w, u, o, a, d);
    exp_q.push_back(e);
    @(negedge clk);
    sel = s; is_wr = w; is_uns = u; op = o; addr = a; wdata = d; avail = 1'b1;
    start = resp_cnt;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (resp_cnt != start) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout: no response to op=%b addr=%h on dut %0d", o, a, s);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      checks++;
      if (busy_s !== 1'b0) begin
        errors++;
        $display("FAIL no_reaccept: busy=%0b while available held", busy_s);
      end
      checks++;
      if ({opf_s, adf_s, acf_s} !== e[39:37]) begin
        errors++;
        $display("FAIL fault_hold: got %b want %b", {opf_s, adf_s, acf_s}, e[39:37]);
      end
      if (e[40]) begin
        checks++;
        if (out_s !== e[36:5]) begin
          errors++;
          $display("FAIL out_hold: got %h want %h", out_s, e[36:5]);
        end
      end
    end
    @(negedge clk);
    avail = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ({busy_s, opf_s, adf_s, acf_s} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_clear: busy/faults got %b want 0000", {busy_s, opf_s, adf_s, acf_s});
    end
  endtask

  task automatic rand_req();
    int s, size, off;
    logic [1:0] o;
    logic [31:0] a;
    s = $urandom_range(0, 1);
    o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    size = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : 4;
    off = $urandom_range(0, 4 * DEPTH - 1);
    if ($urandom_range(0, 3) != 0) off = off - (off % size);
    case ($urandom_range(0, 11))
      0: off = 4 * DEPTH + 4 * $urandom_range(0, 16);
      1: off = -4 * $urandom_range(1, 4);
      default: ;
    endcase
    a = base_of(s) + 32'(off);
    do_req(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, a, $urandom, $urandom_range(0, 3));
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; avail = 1'b0; sel = 0; is_wr = 1'b0; is_uns = 1'b0; op = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_a_flags", {28'h0, ifa.busy, ifa.op_fault, ifa.addr_fault, ifa.access_fault}, 32'h0);
    check_val("rst_a_out", ifa.out, 32'h0);
    check_val("rst_b_flags", {28'h0, ifb.busy, ifb.op_fault, ifb.addr_fault, ifb.access_fault}, 32'h0);
    check_val("rst_b_out", ifb.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        do_req(s, 1'b1, 1'b0, 2'b10, base_of(s) + 32'(4 * i), $urandom, 0);

    do_req(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 0, 0, 2'b10, 32'h10, 32'h0, 1);
    do_req(0, 1, 0, 2'b10, 32'h10, 32'h11223344, 0);
    do_req(0, 1, 0, 2'b00, 32'h13, 32'h000000FF, 0);
    do_req(0, 0, 0, 2'b10, 32'h10, 32'h0, 0);
    do_req(0, 0, 0, 2'b00, 32'h13, 32'h0, 0);
    do_req(0, 0, 1, 2'b00, 32'h13, 32'h0, 0);
    do_req(0, 1, 0, 2'b10, 32'h10, 32'h80017FFF, 0);
    do_req(0, 0, 0, 2'b01, 32'h12, 32'h0, 0);
    do_req(0, 0, 1, 2'b01, 32'h12, 32'h0, 0);
    do_req(0, 1, 0, 2'b01, 32'h11, 32'h0000AAAA, 2);
    do_req(0, 0, 1, 2'b10, 32'h10, 32'h0, 0);
    do_req(0, 0, 0, 2'b11, 32'h0, 32'h0, 2);
    do_req(0, 0, 0, 2'b10, 32'(4 * DEPTH), 32'h0, 1);
    do_req(1, 1, 0, 2'b10, 32'h1008, 32'hA5A55A5A, 0);
    do_req(1, 0, 0, 2'b10, 32'h1008, 32'h0, 5);
    do_req(1, 1, 0, 2'b01, 32'h100A, 32'h00001234, 0);
    do_req(1, 0, 0, 2'b00, 32'h100B, 32'h0, 5);
    do_req(1, 0, 0, 2'b10, 32'h0FFC, 32'h0, 1);
    do_req(1, 0, 0, 2'b10, 32'h1100, 32'h0, 1);

    // Reset in the middle of a write: the write must be lost.
    @(negedge clk);
    sel = 0; is_wr = 1'b1; is_uns = 1'b0; op = 2'b10; addr = 32'h20; wdata = 32'hCAFEF00D; avail = 1'b1;
    @(posedge clk); #2;
    check_val("mid_busy_before", {31'h0, busy_s}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("mid_reset_flags", {28'h0, busy_s, opf_s, adf_s, acf_s}, 32'h0);
    @(negedge clk);
    avail = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 0, 0, 2'b10, 32'h20, 32'h0, 0);

    for (int i = 0; i < 300; i++) rand_req();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
